// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, FSM states and widths shared by the fetch/decode front end
// and control_block.
package cpu_pkg;

    localparam int OPC_W   = 4;
    localparam int INSTR_W = 16;

    localparam logic [OPC_W-1:0] OPC_PUSH      = 4'd0;
    localparam logic [OPC_W-1:0] OPC_POP       = 4'd1;
    localparam logic [OPC_W-1:0] OPC_SUB_SP    = 4'd2;
    localparam logic [OPC_W-1:0] OPC_CMP       = 4'd3;
    localparam logic [OPC_W-1:0] OPC_MOVS      = 4'd4;
    localparam logic [OPC_W-1:0] OPC_MOV       = 4'd5;
    localparam logic [OPC_W-1:0] OPC_LDR       = 4'd6;
    localparam logic [OPC_W-1:0] OPC_STR       = 4'd7;
    localparam logic [OPC_W-1:0] OPC_LDR_NOP   = 4'd8;
    localparam logic [OPC_W-1:0] OPC_ADD_SP    = 4'd9;
    localparam logic [OPC_W-1:0] OPC_BRANCH_NC = 4'd10;
    localparam logic [OPC_W-1:0] OPC_ADDS_3OP  = 4'd11;
    localparam logic [OPC_W-1:0] OPC_BRANCH_C  = 4'd12;
    localparam logic [OPC_W-1:0] OPC_STRB      = 4'd13;
    localparam logic [OPC_W-1:0] OPC_LDRB      = 4'd14;
    localparam logic [OPC_W-1:0] OPC_ADDS_2OP  = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_HOLD,
        ST_FLUSH,
        ST_TRAP
    } fd_state_e;

    // Field layout of a recognised encoding.
    typedef enum logic [2:0] {
        FORM_NONE,
        FORM_OFF,
        FORM_SP,
        FORM_IMM8,
        FORM_2REG,
        FORM_LS,
        FORM_3OP
    } form_e;

endpackage

// File: rtl/thumb16_decoder.sv
// thumb16_decoder: combinational Thumb-16 halfword to control_block opcode
// and register/immediate fields; first matching table entry wins.
module thumb16_decoder
    import cpu_pkg::*;
(
    input  logic [15:0] inst_i,
    output logic [3:0]  opcode_o,
    output logic [2:0]  rd_o,
    output logic [2:0]  rn_o,
    output logic [2:0]  rm_o,
    output logic [7:0]  imm8_o,
    output logic        illegal_o
);

    form_e form;

    // Priority match of the encoding table, selecting opcode and layout.
    always_comb begin
        form      = FORM_NONE;
        opcode_o  = OPC_PUSH;
        illegal_o = 1'b0;
        if (inst_i[15:9] == 7'b1011010) begin
            opcode_o = OPC_PUSH;      form = FORM_OFF;
        end else if (inst_i[15:9] == 7'b1011110) begin
            opcode_o = OPC_POP;       form = FORM_OFF;
        end else if (inst_i[15:7] == 9'b101100001) begin
            opcode_o = OPC_SUB_SP;    form = FORM_SP;
        end else if (inst_i[15:11] == 5'b00101) begin
            opcode_o = OPC_CMP;       form = FORM_IMM8;
        end else if (inst_i[15:11] == 5'b00100) begin
            opcode_o = OPC_MOVS;      form = FORM_IMM8;
        end else if (inst_i[15:8] == 8'b01000110) begin
            opcode_o = OPC_MOV;       form = FORM_2REG;
        end else if (inst_i[15:11] == 5'b01101) begin
            opcode_o = OPC_LDR;       form = FORM_LS;
        end else if (inst_i[15:11] == 5'b01100) begin
            opcode_o = OPC_STR;       form = FORM_LS;
        end else if (inst_i[15:11] == 5'b01001) begin
            opcode_o = OPC_LDR_NOP;   form = FORM_IMM8;
        end else if (inst_i[15:7] == 9'b101100000) begin
            opcode_o = OPC_ADD_SP;    form = FORM_SP;
        end else if (inst_i[15:11] == 5'b11100) begin
            opcode_o = OPC_BRANCH_NC; form = FORM_OFF;
        end else if (inst_i[15:9] == 7'b0001100) begin
            opcode_o = OPC_ADDS_3OP;  form = FORM_3OP;
        end else if (inst_i[15:12] == 4'b1101 && inst_i[11:9] != 3'b111) begin
            opcode_o = OPC_BRANCH_C;  form = FORM_OFF;
        end else if (inst_i[15:11] == 5'b01110) begin
            opcode_o = OPC_STRB;      form = FORM_LS;
        end else if (inst_i[15:11] == 5'b01111) begin
            opcode_o = OPC_LDRB;      form = FORM_LS;
        end else if (inst_i[15:11] == 5'b00110) begin
            opcode_o = OPC_ADDS_2OP;  form = FORM_IMM8;
        end else begin
            illegal_o = 1'b1;
        end
    end

    // Pull fields per layout; anything the layout does not use reads as 0.
    always_comb begin
        rd_o   = 3'd0;
        rn_o   = 3'd0;
        rm_o   = 3'd0;
        imm8_o = 8'd0;
        unique case (form)
            FORM_NONE: ;
            FORM_OFF:  imm8_o = inst_i[7:0];
            FORM_SP:   imm8_o = {1'b0, inst_i[6:0]};
            FORM_IMM8: begin
                rd_o   = inst_i[10:8];
                imm8_o = inst_i[7:0];
            end
            FORM_2REG: begin
                rd_o = inst_i[2:0];
                rn_o = inst_i[5:3];
            end
            FORM_LS: begin
                rd_o   = inst_i[2:0];
                rn_o   = inst_i[5:3];
                imm8_o = {3'b000, inst_i[10:6]};
            end
            FORM_3OP: begin
                rd_o = inst_i[2:0];
                rn_o = inst_i[5:3];
                rm_o = inst_i[8:6];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_fetch_decode.sv
// instr_fetch_decode: single-outstanding Thumb-16 fetch with registered decode,
// stall hold and branch flush. Optional feature macro: ILLEGAL_TRAP_EN.
module instr_fetch_decode
    import cpu_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_rdata,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              instr_valid,
    output logic [3:0]        opcode,
    output logic [2:0]        rd,
    output logic [2:0]        rn,
    output logic [2:0]        rm,
    output logic [7:0]        imm8,
    output logic [ADDR_W-1:0] pc_out,
    output logic              illegal,
    output logic              trap
);

    localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

    fd_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;
    logic [ADDR_W-1:0] pc_out_q, pc_out_d;
    logic [3:0]        opcode_q, opcode_d;
    logic [2:0]        rd_q, rd_d, rn_q, rn_d, rm_q, rm_d;
    logic [7:0]        imm8_q, imm8_d;
    logic              illegal_q, illegal_d;
    logic              req_c;

    logic [3:0] dec_opcode;
    logic [2:0] dec_rd, dec_rn, dec_rm;
    logic [7:0] dec_imm8;
    logic       dec_illegal;

    thumb16_decoder u_dec (
        .inst_i    (imem_rdata),
        .opcode_o  (dec_opcode),
        .rd_o      (dec_rd),
        .rn_o      (dec_rn),
        .rm_o      (dec_rm),
        .imm8_o    (dec_imm8),
        .illegal_o (dec_illegal)
    );

    // Next state, fetch pointer and decode registers; branch outranks ack/stall.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        tgt_d     = tgt_q;
        pc_out_d  = pc_out_q;
        opcode_d  = opcode_q;
        rd_d      = rd_q;
        rn_d      = rn_q;
        rm_d      = rm_q;
        imm8_d    = imm8_q;
        illegal_d = 1'b0;
        req_c     = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_FETCH: begin
                req_c   = 1'b1;
                state_d = ST_FETCH;
                if (branch_taken) begin
                    if (imem_ack) begin
                        pc_d = branch_target;
                    end else begin
                        tgt_d   = branch_target;
                        state_d = ST_FLUSH;
                    end
                end else if (imem_ack) begin
                    pc_out_d = pc_q;
                    if (dec_illegal) begin
                        illegal_d = 1'b1;
                        opcode_d  = 4'd0;
                        rd_d      = 3'd0;
                        rn_d      = 3'd0;
                        rm_d      = 3'd0;
                        imm8_d    = 8'd0;
`ifdef ILLEGAL_TRAP_EN
                        state_d   = ST_TRAP;
`else
                        pc_d      = pc_q + PC_ONE;
`endif
                    end else begin
                        opcode_d = dec_opcode;
                        rd_d     = dec_rd;
                        rn_d     = dec_rn;
                        rm_d     = dec_rm;
                        imm8_d   = dec_imm8;
                        state_d  = ST_DECODE;
                    end
                end
            end
            ST_DECODE, ST_HOLD: begin
                if (branch_taken) begin
                    pc_d    = branch_target;
                    state_d = ST_FETCH;
                end else if (!stall) begin
                    pc_d    = pc_q + PC_ONE;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_FLUSH: begin
                // Old request stays on the bus until acked; its data is dropped.
                req_c = 1'b1;
                if (imem_ack) begin
                    pc_d    = branch_taken ? branch_target : tgt_q;
                    state_d = ST_FETCH;
                end else if (branch_taken) begin
                    tgt_d = branch_target;
                end
            end
            ST_TRAP: ;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= PC_RST;
            tgt_q     <= PC_RST;
            pc_out_q  <= PC_RST;
            opcode_q  <= 4'd0;
            rd_q      <= 3'd0;
            rn_q      <= 3'd0;
            rm_q      <= 3'd0;
            imm8_q    <= 8'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            tgt_q     <= tgt_d;
            pc_out_q  <= pc_out_d;
            opcode_q  <= opcode_d;
            rd_q      <= rd_d;
            rn_q      <= rn_d;
            rm_q      <= rm_d;
            imm8_q    <= imm8_d;
            illegal_q <= illegal_d;
        end
    end

    // IDLE already requests, so the request is masked while reset is held.
    assign imem_req    = req_c & ~rst;
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == ST_DECODE) || (state_q == ST_HOLD);
    assign opcode      = opcode_q;
    assign rd          = rd_q;
    assign rn          = rn_q;
    assign rm          = rm_q;
    assign imm8        = imm8_q;
    assign pc_out      = pc_out_q;
    assign illegal     = illegal_q;
`ifdef ILLEGAL_TRAP_EN
    assign trap        = (state_q == ST_TRAP);
`else
    assign trap        = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_decode.sv
// tb_instr_fetch_decode: directed and random
// fetch/decode stimulus vs a decode model.
module tb_instr_fetch_decode;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [7:0]  branch_target = 8'h00;
  logic        instr_valid;
  logic [3:0]  opcode;
  logic [2:0]  rd, rn, rm;
  logic [7:0]  imm8;
  logic [7:0]  pc_out;
  logic        illegal;
  logic        trap;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_pc = 8'h00;

  always #5 clk = ~clk;

  instr_fetch_decode #(
    .ADDR_W(8),
    .RESET_PC(0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .instr_valid   (instr_valid),
    .opcode        (opcode),
    .rd            (rd),
    .rn            (rn),
    .rm            (rm),
    .imm8          (imm8),
    .pc_out        (pc_out),
    .illegal       (illegal),
    .trap          (trap)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  localparam logic [15:0] MASKS [16] = '{
    16'hFE00, 16'hFE00, 16'hFF80, 16'hF800,
    16'hF800, 16'hFF00, 16'hF800, 16'hF800,
    16'hF800, 16'hFF80, 16'hF800, 16'hFE00,
    16'hF000, 16'hF800, 16'hF800, 16'hF800};
  localparam logic [15:0] MATCHES [16] = '{
    16'hB400, 16'hBC00, 16'hB080, 16'h2800,
    16'h2000, 16'h4600, 16'h6800, 16'h6000,
    16'h4800, 16'hB000, 16'hE000, 16'h1800,
    16'hD000, 16'h7000, 16'h7800, 16'h3000};
  localparam int FORMS [16] = '{
    0, 0, 1, 2, 2, 3, 4, 4,
    2, 1, 0, 5, 0, 4, 4, 2};

  function automatic void ref_dec(
    input  logic [15:0] i,
    output logic [20:0] fields,
    output logic        ill
  );
    logic [3:0] opc;
    logic [2:0] f_rd, f_rn, f_rm;
    logic [7:0] f_imm;
    opc = 4'd0;
    f_rd = 3'd0;
    f_rn = 3'd0;
    f_rm = 3'd0;
    f_imm = 8'd0;
    ill = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (ill &&
          ((i & MASKS[k]) == MATCHES[k]) &&
          !(k == 12 && i[11:9] == 3'b111)) begin
        ill = 1'b0;
        opc = 4'(k);
        case (FORMS[k])
          0: f_imm = i[7:0];
          1: f_imm = {1'b0, i[6:0]};
          2: begin
            f_rd = i[10:8];
            f_imm = i[7:0];
          end
          3: begin
            f_rd = i[2:0];
            f_rn = i[5:3];
          end
          4: begin
            f_rd = i[2:0];
            f_rn = i[5:3];
            f_imm = {3'b000, i[10:6]};
          end
          default: begin
            f_rd = i[2:0];
            f_rn = i[5:3];
            f_rm = i[8:6];
          end
        endcase
      end
    end
    fields = {opc, f_rd, f_rn, f_rm, f_imm};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 8'h00);
    chk("rst_pc_out", pc_out, 8'h00);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_fields",
        {opcode, rd, rn, rm, imm8}, 21'd0);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_trap", trap, 1'b0);
  endtask

  task automatic do_reset();
    imem_ack = 1'b0;
    stall = 1'b0;
    branch_taken = 1'b0;
    #2 rst = 1'b1;
    #1 chk_reset_outputs();
    cyc();
    cyc();
    chk_reset_outputs();
    rst = 1'b0;
    exp_pc = 8'h00;
    #1;
    chk("idle_req", imem_req, 1'b1);
    chk("idle_addr", imem_addr, 8'h00);
  endtask

  task automatic fetch_one(
    input logic [15:0] inst,
    input int          w,
    input int          s,
    input bit          br,
    input logic [7:0]  tgt
  );
    logic [20:0] exp_f;
    logic        ill;
    ref_dec(inst, exp_f, ill);
    chk("req", imem_req, 1'b1);
    chk("addr", imem_addr, exp_pc);
    repeat (w) begin
      cyc();
      chk("wait_req", imem_req, 1'b1);
      chk("wait_addr", imem_addr, exp_pc);
      chk("wait_valid", instr_valid, 1'b0);
    end
    imem_ack = 1'b1;
    imem_rdata = inst;
    cyc();
    imem_ack = 1'b0;
    imem_rdata = 16'($urandom);
    if (ill) begin
      chk("ill_pulse", illegal, 1'b1);
      chk("ill_valid", instr_valid, 1'b0);
      chk("ill_fields",
          {opcode, rd, rn, rm, imm8}, 21'd0);
`ifdef ILLEGAL_TRAP_EN
      chk("trap_set", trap, 1'b1);
      chk("trap_req", imem_req, 1'b0);
      branch_taken = 1'b1;
      branch_target = 8'h33;
      stall = 1'b1;
      repeat (4) begin
        cyc();
        chk("trap_hold", trap, 1'b1);
        chk("trap_noreq", imem_req, 1'b0);
        chk("trap_nvalid", instr_valid, 1'b0);
        chk("trap_ill_once", illegal, 1'b0);
      end
      do_reset();
`else
      chk("no_trap", trap, 1'b0);
      exp_pc = exp_pc + 8'd1;
      chk("skip_req", imem_req, 1'b1);
      chk("skip_addr", imem_addr, exp_pc);
      cyc();
      chk("ill_once", illegal, 1'b0);
      chk("skip_addr2", imem_addr, exp_pc);
`endif
      return;
    end
    chk("valid", instr_valid, 1'b1);
    chk("fields",
        {opcode, rd, rn, rm, imm8}, exp_f);
    chk("pc_out", pc_out, exp_pc);
    chk("no_ill", illegal, 1'b0);
    chk("dec_noreq", imem_req, 1'b0);
    repeat (s) begin
      stall = 1'b1;
      cyc();
      chk("hold_valid", instr_valid, 1'b1);
      chk("hold_fields",
          {opcode, rd, rn, rm, imm8}, exp_f);
      chk("hold_noreq", imem_req, 1'b0);
    end
    if (br) begin
      branch_taken = 1'b1;
      branch_target = tgt;
      stall = 1'($urandom_range(0, 1));
      cyc();
      branch_taken = 1'b0;
      stall = 1'b0;
      exp_pc = tgt;
    end else begin
      stall = 1'b0;
      cyc();
      exp_pc = exp_pc + 8'd1;
    end
    chk("next_nvalid", instr_valid, 1'b0);
    chk("next_req", imem_req, 1'b1);
    chk("next_addr", imem_addr, exp_pc);
  endtask

  task automatic branch_fetch(
    input logic [7:0] tgt,
    input int         w,
    input bit         same_ack
  );
    logic [7:0] old;
    old = exp_pc;
    branch_taken = 1'b1;
    branch_target = tgt;
    imem_ack = same_ack;
    imem_rdata = 16'h2105;
    cyc();
    branch_taken = 1'b0;
    imem_ack = 1'b0;
    if (!same_ack) begin
      repeat (w + 1) begin
        chk("flush_req", imem_req, 1'b1);
        chk("flush_addr", imem_addr, old);
        chk("flush_nvalid", instr_valid, 1'b0);
        if (w > 0) cyc();
        w--;
      end
      imem_ack = 1'b1;
      imem_rdata = 16'hB510;
      cyc();
      imem_ack = 1'b0;
    end
    exp_pc = tgt;
    chk("br_nvalid", instr_valid, 1'b0);
    chk("br_req", imem_req, 1'b1);
    chk("br_addr", imem_addr, tgt);
  endtask

  initial begin
    logic [15:0] inst;
    logic [20:0] f;
    logic        il;
    int          r;

    do_reset();
    fetch_one(16'hB510, 2, 0, 1'b0, 8'h00);
    fetch_one(16'h2105, 0, 3, 1'b0, 8'h00);
    branch_fetch(8'h40, 1, 1'b0);
    fetch_one(16'h4608, 0, 0, 1'b0, 8'h00);
    branch_fetch(8'h80, 0, 1'b1);
    fetch_one(16'h1888, 0, 0, 1'b1, 8'hFF);
    fetch_one(16'h6A51, 1, 1, 1'b0, 8'h00);
    chk("wrap", imem_addr, 8'h00);
    fetch_one(16'hDE00, 0, 0, 1'b0, 8'h00);

    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        branch_fetch(8'($urandom),
                     $urandom_range(0, 2),
                     1'($urandom_range(0, 1)));
      end else begin
        inst = 16'($urandom);
`ifdef ILLEGAL_TRAP_EN
        ref_dec(inst, f, il);
        while (il) begin
          inst = 16'($urandom);
          ref_dec(inst, f, il);
        end
`endif
        fetch_one(inst,
                  $urandom_range(0, 3),
                  $urandom_range(0, 2),
                  r == 1, 8'($urandom));
      end
    end

    fetch_one(16'h2A7F, 0, 0, 1'b0, 8'h00);
    cyc();
    chk("mid_fetch_req", imem_req, 1'b1);
    do_reset();
    fetch_one(16'hB510, 1, 0, 1'b0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
